// File: rtl/frame_sequencer.sv
// Frame-level sequencer for the HUB75 path: LED-domain tick, driver reset/go sequencing,
// continuous or one-shot refresh with frame gap, done-watchdog and front/back bank swap.
module frame_sequencer #(
  parameter int CLOCK_DIV_FACTOR = 1,
  parameter int RST_TICKS        = 2,
  parameter int FRAME_GAP        = 0,
  parameter int ONE_SHOT         = 0,
  parameter int TIMEOUT_TICKS    = 4096,
  parameter int FRAME_CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   drv_done,
  input  logic                   swap_req,
  output logic                   tick,
  output logic                   drv_rst,
  output logic                   drv_go,
  output logic                   front_bank,
  output logic                   swap_ack,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_GO, S_WAIT, S_GAP, S_HALT} state_t;

  localparam int DIV_W   = (CLOCK_DIV_FACTOR > 1) ? $clog2(CLOCK_DIV_FACTOR) : 1;
  localparam int PH_MAX0 = (RST_TICKS > FRAME_GAP) ? RST_TICKS : FRAME_GAP;
  localparam int PH_MAX  = (PH_MAX0 > TIMEOUT_TICKS) ? PH_MAX0 : TIMEOUT_TICKS;
  localparam int PH_W    = $clog2(PH_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIV_FACTOR - 1);
  localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RST_TICKS - 1);
  localparam logic [PH_W-1:0]  GAP_LAST = PH_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
  localparam logic [PH_W-1:0]  WD_LAST  = PH_W'(TIMEOUT_TICKS - 1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [PH_W-1:0]  ph_cnt;
  logic             tick_nxt, go_nxt, drst_nxt;
  logic             frame_done, wd_fire;
  logic             swap_pending, swap_blk, swap_want, do_swap;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // every transition except IDLE entry/exit is qualified by the registered tick
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    wd_fire    = 1'b0;
    if (!enable) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  state_nxt = S_RESET;
        S_RESET: if (tick && ph_cnt == RST_LAST) state_nxt = S_GO;
        S_GO:    if (tick) state_nxt = S_WAIT;
        S_WAIT: begin
          if (tick) begin
            if (drv_done) begin
              frame_done = 1'b1;
              if (ONE_SHOT != 0)     state_nxt = S_HALT;
              else if (FRAME_GAP > 0) state_nxt = S_GAP;
              else                    state_nxt = S_GO;
            end else if (ph_cnt == WD_LAST) begin
              wd_fire   = 1'b1;
              state_nxt = S_RESET;
            end
          end
        end
        S_GAP:   if (tick && ph_cnt == GAP_LAST) state_nxt = S_GO;
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    if (state_nxt == S_IDLE || state == S_IDLE) div_nxt = '0;
    else if (div_cnt == DIV_LAST)               div_nxt = '0;
    else                                        div_nxt = div_cnt + 1'b1;
    tick_nxt  = (state_nxt != S_IDLE) && (div_nxt == DIV_LAST);
    go_nxt    = (state_nxt == S_GO) && tick_nxt;
    drst_nxt  = (state_nxt == S_IDLE) || (state_nxt == S_RESET);
    // after an ack the request is ignored until the writer drops it
    swap_want = swap_req && !swap_ack && !swap_blk;
    do_swap   = frame_done && (swap_pending || swap_want);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      ph_cnt       <= '0;
      tick         <= 1'b0;
      drv_rst      <= 1'b1;
      drv_go       <= 1'b0;
      front_bank   <= 1'b0;
      swap_ack     <= 1'b0;
      swap_pending <= 1'b0;
      swap_blk     <= 1'b0;
      frame_count  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      div_cnt      <= div_nxt;
      tick         <= tick_nxt;
      drv_go       <= go_nxt;
      drv_rst      <= drst_nxt;
      swap_ack     <= do_swap;
      swap_pending <= do_swap ? 1'b0 : (swap_pending | swap_want);
      swap_blk     <= do_swap ? 1'b1 : (swap_req & swap_blk);
      if (do_swap)    front_bank  <= ~front_bank;
      if (frame_done) frame_count <= frame_count + 1'b1;
      timeout_err  <= enable & (timeout_err | wd_fire);
      if (state_nxt != state) ph_cnt <= '0;
      else if (tick)          ph_cnt <= ph_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: two configurations (divided continuous, undivided one-shot)
// driven with shared stimulus and checked every cycle against a tick-arithmetic model.
module tb_frame_sequencer;

  logic clk, rst, enable, drv_done, swap_req;
  logic tick_a, drst_a, go_a, fb_a, ack_a, terr_a;
  logic tick_b, drst_b, go_b, fb_b, ack_b, terr_b;
  logic [3:0] fc_a;
  logic [7:0] fc_b;

  frame_sequencer #(.CLOCK_DIV_FACTOR(3), .RST_TICKS(2), .FRAME_GAP(2), .ONE_SHOT(0),
                    .TIMEOUT_TICKS(8), .FRAME_CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .enable(enable), .drv_done(drv_done), .swap_req(swap_req),
    .tick(tick_a), .drv_rst(drst_a), .drv_go(go_a), .front_bank(fb_a), .swap_ack(ack_a),
    .frame_count(fc_a), .timeout_err(terr_a));

  frame_sequencer #(.CLOCK_DIV_FACTOR(1), .RST_TICKS(2), .FRAME_GAP(0), .ONE_SHOT(1),
                    .TIMEOUT_TICKS(8), .FRAME_CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .drv_done(drv_done), .swap_req(swap_req),
    .tick(tick_b), .drv_rst(drst_b), .drv_go(go_b), .front_bank(fb_b), .swap_ack(ack_b),
    .frame_count(fc_b), .timeout_err(terr_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  localparam int P_RST = 0, P_GO = 1, P_WAIT = 2, P_GAP = 3, P_HALT = 4;

  typedef struct {
    bit run; int ph; int cyc; int pt;
    bit front; bit ack; bit pend; bit blk; bit terr; int fc;
  } m_t;

  m_t ma, mb;

  function automatic bit mtick(m_t m, int div);
    return m.run && ((m.cyc % div) == div - 1);
  endfunction

  function automatic m_t mstep(m_t m, int div, int rstt, int gap, int one, int tmo,
                               bit r, bit en, bit dn, bit sr);
    m_t n;
    bit tk, want, sw;
    n = m; sw = 0;
    tk = mtick(m, div);
    want = sr && !m.ack && !m.blk;
    if (r) begin
      n = '{default:0};
      return n;
    end
    if (!en) begin
      n.run = 0; n.cyc = 0; n.terr = 0;
    end else if (!m.run) begin
      n.run = 1; n.ph = P_RST; n.cyc = 0; n.pt = 0;
    end else begin
      n.cyc = m.cyc + 1;
      if (tk) begin
        case (m.ph)
          P_RST: if (m.pt + 1 == rstt) begin n.ph = P_GO; n.pt = 0; end else n.pt = m.pt + 1;
          P_GO: begin n.ph = P_WAIT; n.pt = 0; end
          P_WAIT: begin
            if (dn) begin
              n.fc = m.fc + 1;
              sw = m.pend || want;
              n.ph = one ? P_HALT : (gap > 0 ? P_GAP : P_GO);
              n.pt = 0;
            end else if (m.pt + 1 == tmo) begin
              n.terr = 1; n.ph = P_RST; n.pt = 0;
            end else n.pt = m.pt + 1;
          end
          P_GAP: if (m.pt + 1 == gap) begin n.ph = P_GO; n.pt = 0; end else n.pt = m.pt + 1;
          default: ;
        endcase
      end
    end
    n.ack = sw;
    if (sw) n.front = !m.front;
    n.pend = sw ? 0 : (m.pend || want);
    n.blk  = sw ? 1 : (sr ? m.blk : 0);
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= mstep(ma, 3, 2, 2, 0, 8, rst, enable, drv_done, swap_req);
    mb <= mstep(mb, 1, 2, 0, 1, 8, rst, enable, drv_done, swap_req);
  end

  // ---------------- checking ----------------
  int n_tests = 0, n_fail = 0, cycn = 0, acks_a = 0;
  int sr_on = -1, sr_off = -1;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cycn);
    end
  endtask

  task automatic cmp_all();
    check("a_tick", tick_a, mtick(ma, 3));
    check("a_rst",  drst_a, !ma.run || ma.ph == P_RST);
    check("a_go",   go_a,   ma.run && ma.ph == P_GO && mtick(ma, 3));
    check("a_fb",   fb_a,   ma.front);
    check("a_ack",  ack_a,  ma.ack);
    check("a_fc",   fc_a,   ma.fc % 16);
    check("a_terr", terr_a, ma.terr);
    check("b_tick", tick_b, mtick(mb, 1));
    check("b_rst",  drst_b, !mb.run || mb.ph == P_RST);
    check("b_go",   go_b,   mb.run && mb.ph == P_GO && mtick(mb, 1));
    check("b_fb",   fb_b,   mb.front);
    check("b_ack",  ack_b,  mb.ack);
    check("b_fc",   fc_b,   mb.fc % 256);
    check("b_terr", terr_b, mb.terr);
  endtask

  task automatic tick_clk();
    @(negedge clk);
    cycn++;
    cmp_all();
    if (ack_a) acks_a++;
    if (cycn == sr_on)  swap_req = 1'b1;
    if (cycn == sr_off) swap_req = 1'b0;
  endtask

  task automatic wait_go_a();
    int n;
    n = 0;
    while (!go_a && n < 200) begin tick_clk(); n++; end
    check("wait_go_a", go_a, 1);
  endtask

  // one frame on config A with done 5 ticks after go
  int last_g = 0;
  task automatic frame_a(input int f, input int fb_pre, input int fb_post, input int ack_exp,
                         input bit swp);
    int g;
    wait_go_a();
    g = cycn;
    if (f > 1) check("t2_go_period", g - last_g, 24);
    last_g = g;
    if (swp) begin sr_on = g + 3; sr_off = g + 23; end
    for (int j = 1; j <= 15; j++) tick_clk();
    check("t3_fb_pre", fb_a, fb_pre);
    drv_done = 1'b1;
    tick_clk();
    drv_done = 1'b0;
    check("t2_count", fc_a, f);
    check("t3_fb_post", fb_a, fb_post);
    check("t3_ack", ack_a, ack_exp);
  endtask

  initial begin
    int g;
    rst = 1'b1; enable = 1'b0; drv_done = 1'b0; swap_req = 1'b0;
    @(posedge clk);
    tick_clk();
    check("rst_tick", tick_a, 0);  check("rst_drst", drst_a, 1);
    check("rst_go", go_a, 0);      check("rst_fb", fb_a, 0);
    check("rst_fc", fc_a, 0);      check("rst_terr", terr_a, 0);
    rst = 1'b0; enable = 1'b1;
    tick_clk();
    // test 1: tick every 3rd clk, drv_rst 2 ticks, go at 3rd tick
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick_clk();
      check("t1_tick", tick_a, (k % 3) == 2);
      check("t1_go",   go_a,   k == 8);
      check("t1_drst", drst_a, k < 6);
    end
    // tests 2/3: gap=2 period, counts, single swap with held request
    frame_a(1, 0, 0, 0, 0);
    frame_a(2, 0, 0, 0, 0);
    frame_a(3, 0, 0, 0, 0);
    frame_a(4, 0, 1, 1, 1);
    frame_a(5, 1, 1, 0, 0);
    check("t3_one_ack", acks_a, 1);
    // test 5: watchdog
    wait_go_a();
    g = cycn;
    for (int j = 1; j <= 33; j++) begin
      tick_clk();
      if (j == 24) check("t5_terr_pre", terr_a, 0);
      if (j == 25) begin
        check("t5_terr", terr_a, 1); check("t5_drst", drst_a, 1); check("t5_fc", fc_a, 5);
      end
      if (j == 30) check("t5_drst_hold", drst_a, 1);
      if (j == 31) check("t5_drst_rel", drst_a, 0);
      if (j == 33) check("t5_go", go_a, 1);
    end
    check("t5_go_cycle", cycn - g, 33);
    // test 6: enable low mid-frame
    for (int j = 1; j <= 4; j++) tick_clk();
    enable = 1'b0;
    tick_clk();
    check("t6_drst", drst_a, 1); check("t6_tick", tick_a, 0); check("t6_terr", terr_a, 0);
    check("t6_fb_keep", fb_a, 1); check("t6_fc_keep", fc_a, 5);
    // test 4: one-shot on config B
    rst = 1'b1;
    tick_clk();
    rst = 1'b0; enable = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick_clk();
      if (k == 2 || k == 18) check("t4_go", go_b, 1);
      if (k == 3 || k == 19) drv_done = 1'b1;
      if (k == 4) begin drv_done = 1'b0; check("t4_fc1", fc_b, 1); end
      if (k >= 5 && k <= 14) begin check("t4_halt_go", go_b, 0); check("t4_halt_rst", drst_b, 0); end
      if (k == 14) enable = 1'b0;
      if (k == 15) enable = 1'b1;
      if (k == 20) begin drv_done = 1'b0; check("t4_fc2", fc_b, 2); end
      if (k == 20) drv_done = 1'b0;
    end
    drv_done = 1'b0;
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      tick_clk();
      enable   = ($urandom_range(0, 99) != 0);
      drv_done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) swap_req = ~swap_req;
      rst      = ($urandom_range(0, 499) == 0);
    end
    // rst mid-frame
    rst = 1'b0; enable = 1'b1; drv_done = 1'b0; swap_req = 1'b0;
    wait_go_a();
    for (int j = 0; j < 3; j++) tick_clk();
    rst = 1'b1;
    tick_clk();
    check("t6r_tick", tick_a, 0); check("t6r_drst", drst_a, 1); check("t6r_go", go_a, 0);
    check("t6r_fb", fb_a, 0);     check("t6r_fc", fc_a, 0);     check("t6r_ack", ack_a, 0);
    check("t6r_fc_b", fc_b, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
